// File: rtl/l1i_pkg.sv
// l1i_pkg: shared widths and types for the L1 instruction cache.
//   l1i_addr_t : fetch/fill address split as {tag, index, offset}
//   l1i_line_t : one cache line entry (valid, tag, optional owner IDs, data)
// All vectors are numbered MSB-first ([0:N-1]); word 0 of a line is leftmost.
// Optional build macro L1I_PID_CHECK_EN adds Pid/Tid owner fields to each entry.
package l1i_pkg;

   localparam int FETCH_ADDR_W = 64;
   localparam int LINE_W       = 512;
   localparam int INSTR_W      = 32;
   localparam int OFFSET_W     = 6;
   localparam int INDEX_W      = 8;
   localparam int TAG_W        = FETCH_ADDR_W - INDEX_W - OFFSET_W;
   localparam int PID_W        = 20;
   localparam int TID_W        = 16;
   localparam int ID_W         = 64;
   localparam int NUM_LINES    = 1 << INDEX_W;
   localparam int WORD_SEL_W   = 4;

   typedef struct packed {
      logic [0:TAG_W-1]    tag;
      logic [0:INDEX_W-1]  index;
      logic [0:OFFSET_W-1] offset;
   } l1i_addr_t;

   typedef struct packed {
      logic                valid;
      logic [0:TAG_W-1]    tag;
`ifdef L1I_PID_CHECK_EN
      logic [0:PID_W-1]    pid;
      logic [0:TID_W-1]    tid;
`endif
      logic [0:LINE_W-1]   data;
   } l1i_line_t;

   // Word w sits at bits [32w : 32w+31] of the line.
   function automatic logic [0:INSTR_W-1] get_word(input logic [0:LINE_W-1]     line,
                                                   input logic [0:WORD_SEL_W-1] w);
      return line[{w, 5'd0} +: INSTR_W];
   endfunction

   // Tag of the line following `index`: carries into the tag when the index wraps.
   function automatic logic [0:TAG_W-1] next_tag(input logic [0:TAG_W-1]   tag,
                                                 input logic [0:INDEX_W-1] index);
      return (index == '1) ? tag + TAG_W'(1) : tag;
   endfunction

endpackage

// File: rtl/l1i_cache_if.sv
// l1i_cache_if: fetch request, fill and fetch/miss response signals of the
// L1 instruction cache. Signal names keep the cache-side _i/_o suffixes.
//   slave  : the cache (takes requests and fills, drives responses)
//   master : the fetch unit / memory side
interface l1i_cache_if;
   import l1i_pkg::*;

   logic                    fetchEnable_i;
   logic                    fetchStall_i;
   logic [0:PID_W-1]        Pid_i;
   logic [0:TID_W-1]        Tid_i;
   logic [0:TAG_W-1]        tag_i;
   logic [0:INDEX_W-1]      index_i;
   logic [0:OFFSET_W-1]     offset_i;

   logic                    cacheUpdate_i;
   logic [0:FETCH_ADDR_W-1] cacheUpdateAddress_i;
   logic [0:LINE_W-1]       cacheUpdateLine1_i;
   logic [0:LINE_W-1]       cacheUpdateLine2_i;
   logic [0:PID_W-1]        cacheUpdatePid_i;
   logic [0:TID_W-1]        cacheUpdateTid_i;

   logic                    fetchEnable1_o;
   logic                    fetchEnable2_o;
   logic [0:INSTR_W-1]      fetchedInstruction1_o;
   logic [0:INSTR_W-1]      fetchedInstruction2_o;
   logic [0:FETCH_ADDR_W-1] fetchedAddress1_o;
   logic [0:FETCH_ADDR_W-1] fetchedAddress2_o;
   logic [0:PID_W-1]        fetchedPid1_o;
   logic [0:PID_W-1]        fetchedPid2_o;
   logic [0:TID_W-1]        fetchedTid1_o;
   logic [0:TID_W-1]        fetchedTid2_o;
   logic [0:ID_W-1]         fetchedInstMajorId1_o;
   logic [0:ID_W-1]         fetchedInstMajorId2_o;

   logic                    cacheMiss_o;
   logic [0:FETCH_ADDR_W-1] missedAddress_o;
   logic [0:ID_W-1]         missedInstMajorId_o;
   logic [0:PID_W-1]        missedPid_o;
   logic [0:TID_W-1]        missedTid_o;

   modport slave (
      input  fetchEnable_i, fetchStall_i, Pid_i, Tid_i, tag_i, index_i, offset_i,
      input  cacheUpdate_i, cacheUpdateAddress_i, cacheUpdateLine1_i, cacheUpdateLine2_i,
      input  cacheUpdatePid_i, cacheUpdateTid_i,
      output fetchEnable1_o, fetchEnable2_o, fetchedInstruction1_o, fetchedInstruction2_o,
      output fetchedAddress1_o, fetchedAddress2_o, fetchedPid1_o, fetchedPid2_o,
      output fetchedTid1_o, fetchedTid2_o, fetchedInstMajorId1_o, fetchedInstMajorId2_o,
      output cacheMiss_o, missedAddress_o, missedInstMajorId_o, missedPid_o, missedTid_o
   );

   modport master (
      output fetchEnable_i, fetchStall_i, Pid_i, Tid_i, tag_i, index_i, offset_i,
      output cacheUpdate_i, cacheUpdateAddress_i, cacheUpdateLine1_i, cacheUpdateLine2_i,
      output cacheUpdatePid_i, cacheUpdateTid_i,
      input  fetchEnable1_o, fetchEnable2_o, fetchedInstruction1_o, fetchedInstruction2_o,
      input  fetchedAddress1_o, fetchedAddress2_o, fetchedPid1_o, fetchedPid2_o,
      input  fetchedTid1_o, fetchedTid2_o, fetchedInstMajorId1_o, fetchedInstMajorId2_o,
      input  cacheMiss_o, missedAddress_o, missedInstMajorId_o, missedPid_o, missedTid_o
   );

endinterface

// File: rtl/l1i_line_ram.sv
// l1i_line_ram: 256-entry valid/tag/data array.
//   Read port : one index, registered entries for lines `idx` and `idx+1`
//               (held while rd_en_i is low).
//   Write port: writes line1 at wr_idx_i and line2 at wr_idx_i+1 (tag carried
//               on index wrap), both marked valid.
//   rst_n     : synchronous active-low, clears valid bits and read registers.
// With L1I_PID_CHECK_EN defined each entry also stores the fill Pid/Tid.
module l1i_line_ram
   import l1i_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rd_en_i,
   input  logic [0:INDEX_W-1] rd_idx_i,
   output l1i_line_t          rd_line0_o,
   output l1i_line_t          rd_line1_o,
   input  logic               wr_en_i,
   input  logic [0:INDEX_W-1] wr_idx_i,
   input  logic [0:TAG_W-1]   wr_tag_i,
`ifdef L1I_PID_CHECK_EN
   input  logic [0:PID_W-1]   wr_pid_i,
   input  logic [0:TID_W-1]   wr_tid_i,
`endif
   input  logic [0:LINE_W-1]  wr_line1_i,
   input  logic [0:LINE_W-1]  wr_line2_i
);

   logic [0:NUM_LINES-1] valid_q, valid_d;
   logic [0:TAG_W-1]     tag_mem  [NUM_LINES];
   logic [0:LINE_W-1]    data_mem [NUM_LINES];
`ifdef L1I_PID_CHECK_EN
   logic [0:PID_W-1]     pid_mem  [NUM_LINES];
   logic [0:TID_W-1]     tid_mem  [NUM_LINES];
`endif

   l1i_line_t          rd_line0_q, rd_line0_d;
   l1i_line_t          rd_line1_q, rd_line1_d;
   l1i_line_t          wr_ent1, wr_ent2;
   logic [0:INDEX_W-1] wr_idx2, rd_idx2;

   assign wr_idx2 = wr_idx_i + INDEX_W'(1);
   assign rd_idx2 = rd_idx_i + INDEX_W'(1);

   always_comb begin
      wr_ent1       = '0;
      wr_ent1.valid = 1'b1;
      wr_ent1.tag   = wr_tag_i;
      wr_ent1.data  = wr_line1_i;
`ifdef L1I_PID_CHECK_EN
      wr_ent1.pid   = wr_pid_i;
      wr_ent1.tid   = wr_tid_i;
`endif
      wr_ent2       = wr_ent1;
      wr_ent2.tag   = next_tag(wr_tag_i, wr_idx_i);
      wr_ent2.data  = wr_line2_i;
   end

   always_comb begin
      valid_d = valid_q;
      if (wr_en_i) begin
         valid_d[wr_idx_i] = 1'b1;
         valid_d[wr_idx2]  = 1'b1;
      end
   end

   // A fill on the same edge as the read wins, so the read never sees stale lines.
   always_comb begin
      rd_line0_d = rd_line0_q;
      rd_line1_d = rd_line1_q;
      if (rd_en_i) begin
         rd_line0_d.valid = valid_q[rd_idx_i];
         rd_line0_d.tag   = tag_mem[rd_idx_i];
         rd_line0_d.data  = data_mem[rd_idx_i];
         rd_line1_d.valid = valid_q[rd_idx2];
         rd_line1_d.tag   = tag_mem[rd_idx2];
         rd_line1_d.data  = data_mem[rd_idx2];
`ifdef L1I_PID_CHECK_EN
         rd_line0_d.pid   = pid_mem[rd_idx_i];
         rd_line0_d.tid   = tid_mem[rd_idx_i];
         rd_line1_d.pid   = pid_mem[rd_idx2];
         rd_line1_d.tid   = tid_mem[rd_idx2];
`endif
         if (wr_en_i && wr_idx_i == rd_idx_i)   rd_line0_d = wr_ent1;
         else if (wr_en_i && wr_idx2 == rd_idx_i) rd_line0_d = wr_ent2;
         if (wr_en_i && wr_idx_i == rd_idx2)    rd_line1_d = wr_ent1;
         else if (wr_en_i && wr_idx2 == rd_idx2)  rd_line1_d = wr_ent2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= '0;
         rd_line0_q <= '0;
         rd_line1_q <= '0;
      end else begin
         valid_q    <= valid_d;
         rd_line0_q <= rd_line0_d;
         rd_line1_q <= rd_line1_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_mem[wr_idx_i]  <= wr_ent1.tag;
         data_mem[wr_idx_i] <= wr_ent1.data;
         tag_mem[wr_idx2]   <= wr_ent2.tag;
         data_mem[wr_idx2]  <= wr_ent2.data;
`ifdef L1I_PID_CHECK_EN
         pid_mem[wr_idx_i]  <= wr_pid_i;
         tid_mem[wr_idx_i]  <= wr_tid_i;
         pid_mem[wr_idx2]   <= wr_pid_i;
         tid_mem[wr_idx2]   <= wr_tid_i;
`endif
      end
   end

   assign rd_line0_o = rd_line0_q;
   assign rd_line1_o = rd_line1_q;

endmodule

// File: rtl/l1i_cache.sv
// l1i_cache: direct-mapped L1 instruction cache, 256 lines of 64 bytes.
//   clock_i      : rising-edge clock
//   cacheReset_i : synchronous active-low reset
//   bus (slave)  : fetch request, line fill, two-slot fetch response, miss request
// Pipeline: request latched (edge N) -> arrays read (N+1) -> hit or miss
// registered (N+2). Slot 2 returns the following word (next line at offset 60).
// A slot-1 miss holds cacheMiss_o, squashes in-flight requests and blocks
// fetches until a fill arrives.
// Build macro L1I_PID_CHECK_EN: lines store fill Pid/Tid and hits require a match.
module l1i_cache
   import l1i_pkg::*;
(
   input logic        clock_i,
   input logic        cacheReset_i,
   l1i_cache_if.slave bus
);

   logic               s0_valid_q, s0_valid_d;
   l1i_addr_t          s0_addr_q,  s0_addr_d;
   logic [0:PID_W-1]   s0_pid_q,   s0_pid_d;
   logic [0:TID_W-1]   s0_tid_q,   s0_tid_d;

   logic               s1_valid_q, s1_valid_d;
   l1i_addr_t          s1_addr_q,  s1_addr_d;
   logic [0:PID_W-1]   s1_pid_q,   s1_pid_d;
   logic [0:TID_W-1]   s1_tid_q,   s1_tid_d;

   logic                    en1_q,   en1_d,   en2_q,   en2_d;
   logic [0:INSTR_W-1]      inst1_q, inst1_d, inst2_q, inst2_d;
   logic [0:FETCH_ADDR_W-1] addr1_q, addr1_d, addr2_q, addr2_d;
   logic [0:PID_W-1]        pid1_q,  pid1_d,  pid2_q,  pid2_d;
   logic [0:TID_W-1]        tid1_q,  tid1_d,  tid2_q,  tid2_d;
   logic [0:ID_W-1]         id1_q,   id1_d,   id2_q,   id2_d;
   logic [0:ID_W-1]         cnt_q,   cnt_d;

   logic                    miss_q,  miss_d;
   logic [0:FETCH_ADDR_W-1] maddr_q, maddr_d;
   logic [0:ID_W-1]         mid_q,   mid_d;
   logic [0:PID_W-1]        mpid_q,  mpid_d;
   logic [0:TID_W-1]        mtid_q,  mtid_d;

   l1i_addr_t               fetch_addr, fill_addr;
   l1i_line_t               ent0, ent1, ent2;
   logic [0:WORD_SEL_W-1]   word1, word2;
   logic                    line_end;
   logic [0:TAG_W-1]        tag2;
   logic [0:FETCH_ADDR_W-1] s1_addr1, s1_addr2;
   logic                    owner1_ok, owner2_ok;
   logic                    hit1, hit2, issue1, issue2, miss_set, accept;
   logic                    fill_addr_unused;

   assign fetch_addr = '{tag: bus.tag_i, index: bus.index_i, offset: bus.offset_i};
   assign fill_addr  = l1i_addr_t'(bus.cacheUpdateAddress_i);
   assign fill_addr_unused = ^fill_addr.offset;

   l1i_line_ram u_line_ram (
      .clk        (clock_i),
      .rst_n      (cacheReset_i),
      .rd_en_i    (!bus.fetchStall_i),
      .rd_idx_i   (s0_addr_q.index),
      .rd_line0_o (ent0),
      .rd_line1_o (ent1),
      .wr_en_i    (bus.cacheUpdate_i),
      .wr_idx_i   (fill_addr.index),
      .wr_tag_i   (fill_addr.tag),
`ifdef L1I_PID_CHECK_EN
      .wr_pid_i   (bus.cacheUpdatePid_i),
      .wr_tid_i   (bus.cacheUpdateTid_i),
`endif
      .wr_line1_i (bus.cacheUpdateLine1_i),
      .wr_line2_i (bus.cacheUpdateLine2_i)
   );

   // Slot 2 is A+4: same line unless A is the last word, then the next line.
   assign word1    = s1_addr_q.offset[0:WORD_SEL_W-1];
   assign word2    = word1 + WORD_SEL_W'(1);
   assign line_end = (word1 == '1);
   assign ent2     = line_end ? ent1 : ent0;
   assign tag2     = line_end ? next_tag(s1_addr_q.tag, s1_addr_q.index) : s1_addr_q.tag;
   assign s1_addr1 = s1_addr_q;
   assign s1_addr2 = s1_addr1 + FETCH_ADDR_W'(4);

`ifdef L1I_PID_CHECK_EN
   assign owner1_ok = (ent0.pid == s1_pid_q) && (ent0.tid == s1_tid_q);
   assign owner2_ok = (ent2.pid == s1_pid_q) && (ent2.tid == s1_tid_q);
`else
   logic fill_owner_unused;
   assign owner1_ok = 1'b1;
   assign owner2_ok = 1'b1;
   assign fill_owner_unused = ^{bus.cacheUpdatePid_i, bus.cacheUpdateTid_i};
`endif

   assign hit1 = ent0.valid && (ent0.tag == s1_addr_q.tag) && owner1_ok;
   assign hit2 = ent2.valid && (ent2.tag == tag2) && owner2_ok;

   assign issue1   = !bus.fetchStall_i && s1_valid_q && hit1;
   assign issue2   = issue1 && hit2;
   assign miss_set = !bus.fetchStall_i && s1_valid_q && !hit1 && !miss_q;
   // A fill retires the miss on this edge, so a fetch alongside it is taken.
   // A request arriving on the edge a miss is detected is squashed like the rest.
   assign accept   = bus.fetchEnable_i && !bus.fetchStall_i
                     && (!miss_q || bus.cacheUpdate_i) && !miss_set;

   always_comb begin
      s0_valid_d = s0_valid_q;
      s0_addr_d  = s0_addr_q;
      s0_pid_d   = s0_pid_q;
      s0_tid_d   = s0_tid_q;
      s1_valid_d = s1_valid_q;
      s1_addr_d  = s1_addr_q;
      s1_pid_d   = s1_pid_q;
      s1_tid_d   = s1_tid_q;
      en1_d      = 1'b0;
      en2_d      = 1'b0;
      inst1_d    = inst1_q;
      inst2_d    = inst2_q;
      addr1_d    = addr1_q;
      addr2_d    = addr2_q;
      pid1_d     = pid1_q;
      pid2_d     = pid2_q;
      tid1_d     = tid1_q;
      tid2_d     = tid2_q;
      id1_d      = id1_q;
      id2_d      = id2_q;
      cnt_d      = cnt_q;
      miss_d     = miss_q;
      maddr_d    = maddr_q;
      mid_d      = mid_q;
      mpid_d     = mpid_q;
      mtid_d     = mtid_q;

      if (!bus.fetchStall_i) begin
         s0_valid_d = accept;
         if (accept) begin
            s0_addr_d = fetch_addr;
            s0_pid_d  = bus.Pid_i;
            s0_tid_d  = bus.Tid_i;
         end
         s1_valid_d = s0_valid_q && !miss_set && !miss_q;
         s1_addr_d  = s0_addr_q;
         s1_pid_d   = s0_pid_q;
         s1_tid_d   = s0_tid_q;

         if (issue1) begin
            en1_d   = 1'b1;
            inst1_d = get_word(ent0.data, word1);
            addr1_d = s1_addr1;
            pid1_d  = s1_pid_q;
            tid1_d  = s1_tid_q;
            id1_d   = cnt_q;
         end
         if (issue2) begin
            en2_d   = 1'b1;
            inst2_d = get_word(ent2.data, word2);
            addr2_d = s1_addr2;
            pid2_d  = s1_pid_q;
            tid2_d  = s1_tid_q;
            id2_d   = cnt_q + ID_W'(1);
         end
         cnt_d = cnt_q + ID_W'(issue1) + ID_W'(issue2);
      end

      if (miss_set) begin
         miss_d  = 1'b1;
         maddr_d = s1_addr1;
         mid_d   = cnt_q;
         mpid_d  = s1_pid_q;
         mtid_d  = s1_tid_q;
      end else if (miss_q && bus.cacheUpdate_i) begin
         miss_d  = 1'b0;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!cacheReset_i) begin
         s0_valid_q <= 1'b0;
         s0_addr_q  <= '0;
         s0_pid_q   <= '0;
         s0_tid_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s1_pid_q   <= '0;
         s1_tid_q   <= '0;
         en1_q      <= 1'b0;
         en2_q      <= 1'b0;
         inst1_q    <= '0;
         inst2_q    <= '0;
         addr1_q    <= '0;
         addr2_q    <= '0;
         pid1_q     <= '0;
         pid2_q     <= '0;
         tid1_q     <= '0;
         tid2_q     <= '0;
         id1_q      <= '0;
         id2_q      <= '0;
         cnt_q      <= '0;
         miss_q     <= 1'b0;
         maddr_q    <= '0;
         mid_q      <= '0;
         mpid_q     <= '0;
         mtid_q     <= '0;
      end else begin
         s0_valid_q <= s0_valid_d;
         s0_addr_q  <= s0_addr_d;
         s0_pid_q   <= s0_pid_d;
         s0_tid_q   <= s0_tid_d;
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
         s1_pid_q   <= s1_pid_d;
         s1_tid_q   <= s1_tid_d;
         en1_q      <= en1_d;
         en2_q      <= en2_d;
         inst1_q    <= inst1_d;
         inst2_q    <= inst2_d;
         addr1_q    <= addr1_d;
         addr2_q    <= addr2_d;
         pid1_q     <= pid1_d;
         pid2_q     <= pid2_d;
         tid1_q     <= tid1_d;
         tid2_q     <= tid2_d;
         id1_q      <= id1_d;
         id2_q      <= id2_d;
         cnt_q      <= cnt_d;
         miss_q     <= miss_d;
         maddr_q    <= maddr_d;
         mid_q      <= mid_d;
         mpid_q     <= mpid_d;
         mtid_q     <= mtid_d;
      end
   end

   assign bus.fetchEnable1_o        = en1_q;
   assign bus.fetchEnable2_o        = en2_q;
   assign bus.fetchedInstruction1_o = inst1_q;
   assign bus.fetchedInstruction2_o = inst2_q;
   assign bus.fetchedAddress1_o     = addr1_q;
   assign bus.fetchedAddress2_o     = addr2_q;
   assign bus.fetchedPid1_o         = pid1_q;
   assign bus.fetchedPid2_o         = pid2_q;
   assign bus.fetchedTid1_o         = tid1_q;
   assign bus.fetchedTid2_o         = tid2_q;
   assign bus.fetchedInstMajorId1_o = id1_q;
   assign bus.fetchedInstMajorId2_o = id2_q;
   assign bus.cacheMiss_o           = miss_q;
   assign bus.missedAddress_o       = maddr_q;
   assign bus.missedInstMajorId_o   = mid_q;
   assign bus.missedPid_o           = mpid_q;
   assign bus.missedTid_o           = mtid_q;

endmodule

// File: tb/tb_l1i_cache.sv
// tb_l1i_cache: directed bench for l1i_cache. Inputs change 1 time unit after
// the rising edge, outputs are sampled at the same point.
module tb_l1i_cache;
   import l1i_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   l1i_cache_if bus();

   l1i_cache u_dut (
      .clock_i      (clk),
      .cacheReset_i (rst_n),
      .bus          (bus)
   );

   int checks = 0;
   int failures = 0;

   localparam logic [PID_W-1:0] PID = 20'h12345;
   localparam logic [TID_W-1:0] TID = 16'hBEEF;

   logic [31:0]       letters [6];
   logic [0:LINE_W-1] line_a, line_b;

   typedef struct {
      logic [7:0]  index;
      logic [5:0]  offset;
      logic [31:0] i1;
      logic [31:0] i2;
      logic        en2;
      logic [63:0] id1;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_fetch(input logic [TAG_W-1:0] tag, input logic [7:0] idx,
                              input logic [5:0] off);
      bus.fetchEnable_i = 1'b1;
      bus.tag_i         = tag;
      bus.index_i       = idx;
      bus.offset_i      = off;
   endtask

   task automatic drive_fill(input logic [TAG_W-1:0] tag, input logic [7:0] idx,
                             input logic [5:0] off);
      bus.cacheUpdate_i        = 1'b1;
      bus.cacheUpdateAddress_i = {tag, idx, off};
      bus.cacheUpdateLine1_i   = line_a;
      bus.cacheUpdateLine2_i   = line_b;
   endtask

   initial begin
      letters = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC,
                  32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};
      for (int w = 0; w < 16; w++) begin
         line_a[w*32 +: 32] = letters[w % 6];
         line_b[w*32 +: 32] = letters[(w + 4) % 6];
      end

      // line 0 (line_a): word w = letters[w%6]; line 1 (line_b): letters[(w+4)%6]
      vecs[0] = '{8'd0, 6'd8,  32'hCCCCCCCC, 32'hDDDDDDDD, 1'b1, 64'd0};
      vecs[1] = '{8'd0, 6'd16, 32'hEEEEEEEE, 32'hFFFFFFFF, 1'b1, 64'd2};
      vecs[2] = '{8'd0, 6'd24, 32'hAAAAAAAA, 32'hBBBBBBBB, 1'b1, 64'd4};
      vecs[3] = '{8'd0, 6'd32, 32'hCCCCCCCC, 32'hDDDDDDDD, 1'b1, 64'd6};
      vecs[4] = '{8'd0, 6'd60, 32'hDDDDDDDD, 32'hEEEEEEEE, 1'b1, 64'd8};
      vecs[5] = '{8'd1, 6'd60, 32'hBBBBBBBB, 32'h00000000, 1'b0, 64'd10};

      bus.fetchEnable_i        = 1'b0;
      bus.fetchStall_i         = 1'b0;
      bus.Pid_i                = PID;
      bus.Tid_i                = TID;
      bus.tag_i                = '0;
      bus.index_i              = '0;
      bus.offset_i             = '0;
      bus.cacheUpdate_i        = 1'b0;
      bus.cacheUpdateAddress_i = '0;
      bus.cacheUpdateLine1_i   = '0;
      bus.cacheUpdateLine2_i   = '0;
      bus.cacheUpdatePid_i     = PID;
      bus.cacheUpdateTid_i     = TID;

      // Reset state
      step();
      step();
      chk("rst_miss",  64'(bus.cacheMiss_o), 64'd0);
      chk("rst_en1",   64'(bus.fetchEnable1_o), 64'd0);
      chk("rst_en2",   64'(bus.fetchEnable2_o), 64'd0);
      chk("rst_maddr", 64'(bus.missedAddress_o), 64'd0);
      rst_n = 1'b1;
      step();

      // Cold miss at address 4
      drive_fetch('0, 8'd0, 6'd4);
      step();
      bus.fetchEnable_i = 1'b0;
      step();
      chk("miss_early", 64'(bus.cacheMiss_o), 64'd0);
      step();
      chk("miss_set",   64'(bus.cacheMiss_o), 64'd1);
      chk("miss_addr",  64'(bus.missedAddress_o), 64'd4);
      chk("miss_id",    64'(bus.missedInstMajorId_o), 64'd0);
      chk("miss_pid",   64'(bus.missedPid_o), 64'(PID));
      chk("miss_en1",   64'(bus.fetchEnable1_o), 64'd0);

      // Refetch while the miss is pending is dropped
      drive_fetch('0, 8'd0, 6'd0);
      step();
      bus.fetchEnable_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pend_en1", 64'(bus.fetchEnable1_o), 64'd0);
      end
      chk("pend_miss",  64'(bus.cacheMiss_o), 64'd1);
      chk("pend_maddr", 64'(bus.missedAddress_o), 64'd4);

      // Fill resolves the miss on the sampling edge
      drive_fill('0, 8'd0, 6'd4);
      step();
      bus.cacheUpdate_i = 1'b0;
      chk("fill_clear", 64'(bus.cacheMiss_o), 64'd0);

      // Back-to-back fetches, outputs two edges after each request's latch edge
      for (int i = 0; i < 8; i++) begin
         if (i < 6) drive_fetch('0, vecs[i].index, vecs[i].offset);
         else       bus.fetchEnable_i = 1'b0;
         step();
         if (i >= 2) begin
            vec_t v;
            logic [63:0] a1;
            v  = vecs[i-2];
            a1 = {50'd0, v.index, v.offset};
            chk($sformatf("v%0d_en1", i-2),  64'(bus.fetchEnable1_o), 64'd1);
            chk($sformatf("v%0d_i1", i-2),   64'(bus.fetchedInstruction1_o), 64'(v.i1));
            chk($sformatf("v%0d_a1", i-2),   64'(bus.fetchedAddress1_o), a1);
            chk($sformatf("v%0d_id1", i-2),  64'(bus.fetchedInstMajorId1_o), v.id1);
            chk($sformatf("v%0d_en2", i-2),  64'(bus.fetchEnable2_o), 64'(v.en2));
            if (v.en2) begin
               chk($sformatf("v%0d_i2", i-2),  64'(bus.fetchedInstruction2_o), 64'(v.i2));
               chk($sformatf("v%0d_a2", i-2),  64'(bus.fetchedAddress2_o), a1 + 64'd4);
               chk($sformatf("v%0d_id2", i-2), 64'(bus.fetchedInstMajorId2_o), v.id1 + 64'd1);
            end
         end
      end
      chk("tid1", 64'(bus.fetchedTid1_o), 64'(TID));
      step();
      chk("pulse_en1", 64'(bus.fetchEnable1_o), 64'd0);
      chk("pulse_en2", 64'(bus.fetchEnable2_o), 64'd0);

      // Fill at index 255 with a fetch on the same edge: slot 2 wraps to index 0, tag+1
      drive_fill(50'd3, 8'd255, 6'd0);
      drive_fetch(50'd3, 8'd255, 6'd60);
      step();
      bus.cacheUpdate_i = 1'b0;
      bus.fetchEnable_i = 1'b0;
      step();
      step();
      chk("wrap_en1", 64'(bus.fetchEnable1_o), 64'd1);
      chk("wrap_i1",  64'(bus.fetchedInstruction1_o), 64'hDDDDDDDD);
      chk("wrap_en2", 64'(bus.fetchEnable2_o), 64'd1);
      chk("wrap_i2",  64'(bus.fetchedInstruction2_o), 64'hEEEEEEEE);
      chk("wrap_a2",  64'(bus.fetchedAddress2_o), 64'h10000);
      chk("wrap_id1", 64'(bus.fetchedInstMajorId1_o), 64'd11);
      chk("wrap_id2", 64'(bus.fetchedInstMajorId2_o), 64'd12);
      chk("wrap_miss", 64'(bus.cacheMiss_o), 64'd0);

      // Reset with a request in flight
      drive_fetch(50'd4, 8'd0, 6'd0);
      step();
      bus.fetchEnable_i = 1'b0;
      rst_n = 1'b0;
      step();
      chk("mrst_en1",  64'(bus.fetchEnable1_o), 64'd0);
      chk("mrst_i1",   64'(bus.fetchedInstruction1_o), 64'd0);
      chk("mrst_a1",   64'(bus.fetchedAddress1_o), 64'd0);
      chk("mrst_id1",  64'(bus.fetchedInstMajorId1_o), 64'd0);
      chk("mrst_pid1", 64'(bus.fetchedPid1_o), 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mrst_squash", 64'(bus.fetchEnable1_o), 64'd0);
      end
      drive_fetch('0, 8'd0, 6'd8);
      step();
      bus.fetchEnable_i = 1'b0;
      step();
      step();
      chk("post_miss",  64'(bus.cacheMiss_o), 64'd1);
      chk("post_maddr", 64'(bus.missedAddress_o), 64'd8);
      chk("post_mid",   64'(bus.missedInstMajorId_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l1i_cache.md
# l1i_cache

Direct-mapped level-1 instruction cache at the front of the fetch pipeline. It accepts a split fetch address and returns up to two consecutive 32-bit instructions per hit, each tagged with address, Pid, Tid and a unique 64-bit instruction ID. On a miss it raises a held miss request to the next memory level. It then blocks further fetches until a two-line update resolves the miss.

## Interface
- fetchingAddressWidth, 64, fetch address width
- cacheLineWith, 512, line width in bits (64 bytes)
- instructionWidth, 32, instruction width
- offsetWidth, 6, byte offset within a line
- indexWidth, 8, index width (256 lines)
- tagWidth, fetchingAddressWidth-indexWidth-offsetWidth, tag width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, instruction ID width
- clock_i  in  1  single clock, rising edge
- cacheReset_i  in  1  reset, synchronous, active-low
- fetchEnable_i  in  1  fetch request strobe
- fetchStall_i  in  1  downstream stall; freezes the pipeline
- Pid_i / Tid_i  in  PidSize / TidSize  requester IDs
- tag_i / index_i / offset_i  in  tagWidth / indexWidth / offsetWidth  fetch address fields
- cacheUpdate_i  in  1  line fill strobe
- cacheUpdateAddress_i  in  64  fill address, ordered {tag, index, offset}
- cacheUpdateLine1_i / cacheUpdateLine2_i  in  512  fill data for line `index` and line `index+1`
- cacheUpdatePid_i / cacheUpdateTid_i  in  PidSize / TidSize  fill owner IDs
- fetchEnable1_o / fetchEnable2_o  out  1  instruction slot valid
- fetchedInstruction1_o / fetchedInstruction2_o  out  32  instruction words
- fetchedAddress1_o / fetchedAddress2_o  out  64  instruction addresses
- fetchedPid1_o / fetchedPid2_o / fetchedTid1_o / fetchedTid2_o  out  PidSize / TidSize  passthrough IDs
- fetchedInstMajorId1_o / fetchedInstMajorId2_o  out  64  instruction IDs
- cacheMiss_o  out  1  miss outstanding
- missedAddress_o / missedInstMajorId_o  out  64 / 64  address and ID of the missed instruction
- missedPid_o / missedTid_o  out  PidSize / TidSize  missed requester IDs

## Operation
- All vectors use MSB-first numbering, `[0:N-1]`.
- Instruction word w of a line occupies bits `[32w : 32w+31]`; w = `offset[0:3]`. Word 0 is leftmost (big-endian).
- Each line stores valid, tag and 512 bits of data.
- Slot 1 (address A):
  - Hit requires valid and tag match.
  - On a miss, `cacheMiss_o` is set and the missed fields are loaded. The ID counter is not advanced.
- Slot 2 (address A+4):
  - If offset = 60, slot 2 reads line `index+1`; the tag carries +1 when the index wraps from 255 to 0.
  - A slot-2 miss only clears `fetchEnable2_o`; it never raises a miss.
- ID counter (64-bit):
  - Id1 = counter, Id2 = counter+1.
  - Advances by the number of slots issued.
- Fill:
  - Writes line1 at the fill index with the fill tag, and line2 at `index+1` (same tag carry rule).
  - Sets both lines valid.
  - Clears the miss state.
- While a miss is outstanding:
  - `fetchEnable_i` is ignored.
  - Requests already in flight are squashed.

## Timing
- Latency:
  - Edge N: request latched.
  - Edge N+1: arrays read.
  - Edge N+2: hit outputs or `cacheMiss_o` registered.
- Throughput is one request per cycle.
- Hit enables pulse for one cycle.
- `cacheMiss_o` is held until the edge that samples `cacheUpdate_i`=1, and deasserts on that edge.
- Fill and fetch in the same cycle: the fill is written first. The fetch is accepted and reads the new data.
- `fetchStall_i`=1: stage registers hold, no request is accepted, and both fetch enables are 0.
- Reset (`cacheReset_i`=0 at an edge, including mid-operation):
  - All valid bits, the pipeline, the miss state and the counter are cleared.
  - All outputs go to 0.

## Configuration
- `L1I_PID_CHECK_EN` defined: each line also stores the fill Pid/Tid, and a hit additionally requires Pid/Tid match.
- Undefined: Pid/Tid are passthrough only.

## Structure
- Package `l1i_pkg` holds the width constants, the `{tag, index, offset}` address-field typedef and the line-entry typedef.
- One sub-module, `l1i_line_ram`: 256-entry tag/valid/data array with one read port and a dual-line write port.

## Test plan
- Reset, then fetch at tag 0, index 0, offset 4 -> `cacheMiss_o`=1 after 3 edges, `missedAddress_o`=4, `missedInstMajorId_o`=0.
- Refetch at address 0 while the miss is pending -> request dropped, no output change.
- Fill at address 4 with line1 = `AAAAAAAA BBBBBBBB CCCCCCCC DDDDDDDD EEEEEEEE FFFFFFFF ...` -> `cacheMiss_o`=0.
- Back-to-back fetches at offsets 8, 16, 24, 32 -> on consecutive cycles:
  - offset 8: `CCCCCCCC` / `DDDDDDDD`
  - offset 16: `EEEEEEEE` / `FFFFFFFF`
  - offset 24: `AAAAAAAA` / `BBBBBBBB`
  - offset 32: `CCCCCCCC` / `DDDDDDDD`
  - IDs 0..7 across the four fetches.
- Fetch at offset 60 -> slot 1 = word 15 of line 0 (`DDDDDDDD`), slot 2 = word 0 of line 1 (`EEEEEEEE`).
- Reset asserted mid-stream -> all outputs 0 and counter 0; a subsequent fetch at address 8 misses.
